// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the register-bank responder: the response
// record carried through the output buffer and per-register reset lookup.
package reg_bank_pkg;

    // Data width carried by the response record; the top-level DATA_WIDTH
    // parameter is expected to match it.
    localparam int RSP_DATA_WIDTH = 4;
    localparam int MAX_REGS       = 16;
    localparam int PATTERN_MAX_W  = RSP_DATA_WIDTH * MAX_REGS;

    typedef struct packed {
        logic                      write;
        logic                      err;
        logic [RSP_DATA_WIDTH-1:0] rdata;
    } rsp_t;

    localparam rsp_t RSP_EMPTY = {1'b0, 1'b0, {RSP_DATA_WIDTH{1'b0}}};

    // Reset value of register idx, taken from a concatenated pattern.
    function automatic logic [RSP_DATA_WIDTH-1:0] reset_value(
        input logic [PATTERN_MAX_W-1:0] pattern,
        input int unsigned              idx
    );
        return pattern[idx*RSP_DATA_WIDTH +: RSP_DATA_WIDTH];
    endfunction

endpackage

// File: rtl/reg_bank_rsp_fifo.sv
// Two-entry in-order response buffer. Entries shift toward the head slot so
// the head is always a register, keeping the rsp_* outputs flop-driven.
module reg_bank_rsp_fifo
    import reg_bank_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  rsp_t       push_data,
    input  logic       pop,
    output rsp_t       head,
    output logic [1:0] count
);

    rsp_t       head_q, head_d;
    rsp_t       tail_q, tail_d;
    logic [1:0] count_q, count_d;

    // Next-state of the two slots and occupancy for every push/pop combination.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = push_data;
                    count_d = 2'd1;
                end else begin
                    count_d = 2'd0;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = push_data;
                end else if (push) begin
                    tail_d  = push_data;
                    count_d = 2'd2;
                end else if (pop) begin
                    head_d  = RSP_EMPTY;
                    count_d = 2'd0;
                end else begin
                    count_d = 2'd1;
                end
            end
            2'd2: begin
                if (push && pop) begin
                    head_d = tail_q;
                    tail_d = push_data;
                end else if (pop) begin
                    head_d  = tail_q;
                    tail_d  = RSP_EMPTY;
                    count_d = 2'd1;
                end else begin
                    count_d = 2'd2;
                end
            end
            default: begin
                head_d  = RSP_EMPTY;
                tail_d  = RSP_EMPTY;
                count_d = 2'd0;
            end
        endcase
    end

    // Slot and occupancy registers; reset discards any pending responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= RSP_EMPTY;
            tail_q  <= RSP_EMPTY;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head  = head_q;
    assign count = count_q;

endmodule

// File: rtl/reg_bank_responder.sv
// Responder for single-beat register read/write requests: decodes the request,
// updates the register bank and queues one response per accepted request.
module reg_bank_responder
    import reg_bank_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_REGS   = 4,
    parameter int ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH*NUM_REGS-1:0] RESET_PATTERN = 16'h3210
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata
);

    localparam logic [PATTERN_MAX_W-1:0] PATTERN_EXT  = PATTERN_MAX_W'(RESET_PATTERN);
    localparam logic [ADDR_WIDTH:0]      NUM_REGS_CMP = (ADDR_WIDTH+1)'(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  req_ready_s;
    logic                  accept_s;
    logic                  pop_s;
    logic                  in_range_s;
    logic [DATA_WIDTH-1:0] rd_value_s;
    rsp_t                  push_data_s;
    rsp_t                  head_s;
    logic [1:0]            count_s;

    // Ready depends only on buffer occupancy (registered) and is held low in reset.
    assign req_ready_s = rst_n & (count_s != 2'd2);
    assign accept_s    = req_valid & req_ready_s;
    assign pop_s       = (count_s != 2'd0) & rsp_ready;

    // Address decode, pre-edge register read and response record formation.
    always_comb begin
        in_range_s = ({1'b0, req_addr} < NUM_REGS_CMP);
        rd_value_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_value_s = (req_addr == ADDR_WIDTH'(i)) ? regs_q[i] : rd_value_s;
        end
        push_data_s.write = req_write;
        push_data_s.err   = ~in_range_s;
        if (!in_range_s) begin
            push_data_s.rdata = {DATA_WIDTH{1'b0}};
        end else if (req_write) begin
            push_data_s.rdata = req_wdata;
        end else begin
            push_data_s.rdata = rd_value_s;
        end
    end

    // Register bank next state: clear overrides any write on the same edge.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (clear) begin
                regs_d[i] = reset_value(PATTERN_EXT, i);
            end else if (accept_s && req_write && in_range_s && (req_addr == ADDR_WIDTH'(i))) begin
                regs_d[i] = req_wdata;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Register bank storage with asynchronous return to the reset pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= reset_value(PATTERN_EXT, i);
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    reg_bank_rsp_fifo u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s)
    );

    assign req_ready = req_ready_s;
    assign rsp_valid = (count_s != 2'd0);
    assign rsp_write = head_s.write;
    assign rsp_err   = head_s.err;
    assign rsp_rdata = head_s.rdata;

endmodule
